// File: rtl/clk_switch_pkg.sv
// Shared types and constants for the AXI/pixel clock-switch sequencer.
package clk_switch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StOff,
        StCheck,
        StOn,
        StResp
    } sw_state_e;

    localparam logic CLK_SEL_AXI = 1'b0;
    localparam logic CLK_SEL_PIX = 1'b1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bit_sync_edge.sv
// Two-flop synchronizer followed by an edge detector; pulses once per input transition.
module bit_sync_edge (
    input  logic clk0,
    input  logic clk0_rst_n,
    input  logic din,
    output logic pulse
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk0 or negedge clk0_rst_n) begin
        if (!clk0_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse = sync2_q ^ prev_q;

endmodule

// File: rtl/clk_switch_ctrl.sv
// Break-before-make sequencer for the glitch-free AXI (clk0) / pixel (clk1) clock switch.
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int unsigned OFF_CYCLES    = 8,
    parameter int unsigned ON_CYCLES     = 8,
    parameter int unsigned ALIVE_TIMEOUT = 256,
    parameter int unsigned CNT_W         = $clog2(max3(OFF_CYCLES, ON_CYCLES, ALIVE_TIMEOUT) + 1)
) (
    input  logic clk0,
    input  logic clk0_rst_n,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic resp_valid,
    output logic resp_sel,
    output logic resp_err,
    input  logic clk1_beat,
    output logic clk0_enable,
    output logic clk1_enable,
    output logic cur_sel,
    output logic busy
);

    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALIVE_LAST = CNT_W'(ALIVE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    sw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             edge_seen_q, edge_seen_d;
    logic             target_q, target_d;
    logic             old_q, old_d;
    logic             err_q, err_d;
    logic             cur_sel_q, cur_sel_d;
    logic             clk0_en_q, clk0_en_d;
    logic             clk1_en_q, clk1_en_d;
    logic             beat_edge;
    logic             enter_on;
    logic             on_sel;

    bit_sync_edge u_beat_sync (
        .clk0       (clk0),
        .clk0_rst_n (clk0_rst_n),
        .din        (clk1_beat),
        .pulse      (beat_edge)
    );

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        edge_seen_d = edge_seen_q;
        target_d    = target_q;
        old_d       = old_q;
        err_d       = err_q;
        cur_sel_d   = cur_sel_q;
        clk0_en_d   = clk0_en_q;
        clk1_en_d   = clk1_en_q;
        enter_on    = 1'b0;
        on_sel      = target_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req_valid) begin
                    target_d = req_sel;
                    old_d    = cur_sel_q;
                    if (req_sel == cur_sel_q) begin
                        state_d = StResp;
                    end else begin
                        state_d   = StOff;
                        clk0_en_d = 1'b0;
                        clk1_en_d = 1'b0;
                    end
                end
            end
            StOff: begin
                cnt_d = cnt_inc;
                if (cnt_q == OFF_LAST) begin
                    cnt_d       = '0;
                    edge_seen_d = 1'b0;
                    // clk0 never stops, so only a move to clk1 needs a liveness check
                    if (target_q == CLK_SEL_PIX) begin
                        state_d = StCheck;
                    end else begin
                        enter_on = 1'b1;
                    end
                end
            end
            StCheck: begin
                cnt_d = cnt_inc;
                if (beat_edge && edge_seen_q) begin
                    enter_on = 1'b1;
                end else if (cnt_q == ALIVE_LAST) begin
                    err_d    = 1'b1;
                    target_d = old_q;
                    on_sel   = old_q;
                    enter_on = 1'b1;
                end else if (beat_edge) begin
                    edge_seen_d = 1'b1;
                end
            end
            StOn: begin
                cnt_d = cnt_inc;
                if (cnt_q == ON_LAST) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (enter_on) begin
            state_d   = StOn;
            cnt_d     = '0;
            cur_sel_d = on_sel;
            clk0_en_d = (on_sel == CLK_SEL_AXI);
            clk1_en_d = (on_sel == CLK_SEL_PIX);
        end
    end

    always_ff @(posedge clk0 or negedge clk0_rst_n) begin
        if (!clk0_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            edge_seen_q <= 1'b0;
            target_q    <= CLK_SEL_AXI;
            old_q       <= CLK_SEL_AXI;
            err_q       <= 1'b0;
            cur_sel_q   <= CLK_SEL_AXI;
            clk0_en_q   <= 1'b1;
            clk1_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            edge_seen_q <= edge_seen_d;
            target_q    <= target_d;
            old_q       <= old_d;
            err_q       <= err_d;
            cur_sel_q   <= cur_sel_d;
            clk0_en_q   <= clk0_en_d;
            clk1_en_q   <= clk1_en_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign resp_valid  = (state_q == StResp);
    assign resp_sel    = cur_sel_q;
    assign resp_err    = err_q;
    assign cur_sel     = cur_sel_q;
    assign clk0_enable = clk0_en_q;
    assign clk1_enable = clk1_en_q;

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Sequencer that drives the enable inputs of the glitch-free AXI/pixel clock switch (clk0 = AXI clock, clk1 = pixel clock).
- Accepts a select request over a valid/ready handshake.
- Switches in break-before-make order: drops the current enable, waits for the switch synchronizers to drain, confirms clk1 is toggling, then raises the target enable and reports completion.
- Sits in the always-on clk0 (AXI) domain, next to the clock switch, under DMA control.

Parameters:
- OFF_CYCLES, 8: clk0 cycles with both enables low before the target enable is raised (≥ 3 slowest-clock periods).
- ON_CYCLES, 8: clk0 cycles after the target enable rises before the response is issued.
- ALIVE_TIMEOUT, 256: maximum clk0 cycles spent waiting for clk1 activity.
- CNT_W, $clog2(max(OFF_CYCLES,ON_CYCLES,ALIVE_TIMEOUT)+1): width of the shared cycle counter.

Ports:
- clk0  in  1  AXI clock; always running; the block's only clock.
- clk0_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  switch request valid.
- req_sel  in  1  requested clock: 0 = clk0, 1 = clk1.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_sel  out  1  clock actually active at completion.
- resp_err  out  1  qualified by resp_valid; 1 = clk1 not alive, reverted to clk0.
- clk1_beat  in  1  toggle flop driven in the clk1 domain (inverts every clk1 cycle); asynchronous to clk0.
- clk0_enable  out  1  to clock switch; registered.
- clk1_enable  out  1  to clock switch; registered.
- cur_sel  out  1  currently selected clock.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset and clocking: reset clk0_rst_n, asynchronous, active-low; clock clk0.
- Reset values: clk0_enable=1, clk1_enable=0, cur_sel=0, req_ready=1, resp_valid=0, resp_sel=0, resp_err=0, busy=0, state=IDLE, counter=0, sync flops=0.
- States: IDLE, OFF, CHECK, ON, RESP.
- Accept: req_valid&&req_ready at cycle T0. The block latches target=req_sel and old=cur_sel.
- IDLE, target==cur_sel: go to RESP. resp_valid=1 at T0+1 with resp_sel=cur_sel, resp_err=0; enables unchanged.
- IDLE, target!=cur_sel: go to OFF. Both enables are 0 from T0+1. OFF lasts exactly OFF_CYCLES cycles.
- OFF exit: target=1 goes to CHECK; target=0 goes straight to ON, because clk0 is always alive.
- CHECK:
  - clk1_beat passes through a 2-flop synchronizer plus an edge-detect flop.
  - Counter and edge count are cleared on entry.
  - On the cycle the 2nd detected edge occurs, go to ON with target=1.
  - If the counter reaches ALIVE_TIMEOUT first, set err and go to ON with target=old (0).
  - Edges are counted only while in CHECK.
- ON:
  - The target enable is 1 from the first ON cycle; the other enable stays 0.
  - ON lasts ON_CYCLES cycles, then the block goes to RESP.
  - cur_sel updates to target on entry to ON.
- RESP: resp_valid=1 for one cycle, resp_sel=cur_sel, resp_err=err. Next state is IDLE; err is cleared.
- Latency, default parameters:
  - clk1→clk0: clk0_enable rises at T0+9, resp_valid at T0+17.
  - clk0→clk1: clk1_enable rises at T0+9+N+1, where N is the CHECK cycle on which the 2nd edge is detected (0-based).
- Invariant: clk0_enable&&clk1_enable is never 1 in any cycle, including around reset.
- Requests presented while busy are not accepted (req_ready=0) and have no effect. A request held through busy is accepted in the next IDLE cycle.
- Reset mid-operation: immediate return to reset values (clk0 enabled), no resp_valid. The external switch's own interlock handles the transient.
- Counter saturates; it never wraps within a state.

Decomposition:
- Package clk_switch_pkg:
  - state enum typedef (IDLE/OFF/CHECK/ON/RESP).
  - constants CLK_SEL_AXI=1'b0, CLK_SEL_PIX=1'b1.
- Sub-module bit_sync_edge: 2-flop synchronizer plus edge detect, clocked on clk0, reset clk0_rst_n; output pulses once per input transition. Reusable elsewhere in the DMA.

Test Plan:
- Reset:
  - Stimulus: assert clk0_rst_n low, then release.
  - Required: clk0_enable=1, clk1_enable=0, cur_sel=0, req_ready=1, busy=0, resp_valid=0.
- clk0→clk1, clk1 alive:
  - Stimulus: req_sel=1 with clk1_beat toggling every 3 clk0 cycles.
  - Required: both enables 0 over T0+1..T0+8; clk1_enable=1 after the 2nd synced edge; resp_valid ON_CYCLES later with resp_sel=1, resp_err=0, cur_sel=1; enables never both 1.
- clk0→clk1, clk1 dead:
  - Stimulus: req_sel=1 with clk1_beat held constant.
  - Required: CHECK for 256 cycles, clk0_enable back to 1, resp_valid with resp_sel=0, resp_err=1, cur_sel=0.
- clk1→clk0:
  - Stimulus: request req_sel=0 while on clk1.
  - Required: clk1_enable=0 at T0+1, clk0_enable=1 at T0+9, resp_valid at T0+17, resp_sel=0.
- Same-select and busy requests:
  - Stimulus: req_sel equal to cur_sel.
  - Required: resp_valid at T0+1 with resp_err=0 and no enable change.
  - Stimulus: req_valid pulsed while busy.
  - Required: ignored.
- Reset mid-CHECK:
  - Stimulus: assert clk0_rst_n low during CHECK.
  - Required: within the same cycle clk0_enable=1, clk1_enable=0, state IDLE, no resp_valid.
